// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: RV32I fetch stage with in-order imem req/gnt/rvalid handshake,
// a small {pc, instr} queue toward decode, and redirect with stale-response dropping.
module rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSel,
  input  logic [31:0] i_alu_result,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_ready
);
  localparam int            PW  = $clog2(DEPTH);
  localparam int            CW  = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEP = CW'(DEPTH);
  typedef enum logic [1:0] {RESET, RUN, FLUSH} state_t;
  state_t        state;
  logic [31:0]   fpc, resp_pc, target;
  logic [CW-1:0] outstanding, drop, cnt, inflight, nxt_inflight;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          grant, resp, push, pop, redirect;
  assign target        = i_alu_result & ~32'h3;
  assign pop           = o_valid & i_ready;
  // a head leaving this cycle frees its slot, so back-to-back fetch sustains one per cycle
  assign o_imem_req    = state == RUN && (outstanding + cnt - CW'(pop)) < DEP;
  assign o_imem_addr   = fpc;
  assign grant         = o_imem_req & i_imem_gnt;
  assign inflight      = outstanding + drop;
  assign resp          = i_imem_rvalid && inflight != '0;
  assign push          = resp && state == RUN;
  assign redirect      = PCSel && state != RESET;
  assign nxt_inflight  = inflight + CW'(grant) - CW'(resp);
  assign o_valid       = cnt != '0;
  assign o_instruction = o_valid ? q_instr[rd_ptr] : 32'h0000_0013;
  assign o_pc          = o_valid ? q_pc[rd_ptr] : resp_pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= RESET;
      fpc         <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      cnt         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      state       <= nxt_inflight != '0 ? FLUSH : RUN;
      fpc         <= target;
      resp_pc     <= target;
      drop        <= nxt_inflight;
      outstanding <= '0;
      cnt         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (state == RESET || (state == FLUSH && nxt_inflight == '0)) state <= RUN;
      if (grant) fpc <= fpc + 32'd4;
      if (push) resp_pc <= resp_pc + 32'd4;
      if (state == FLUSH) drop <= drop - CW'(resp);
      outstanding <= outstanding + CW'(grant) - CW'(push);
      cnt         <= cnt + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr_ptr]    <= resp_pc;
      q_instr[wr_ptr] <= i_imem_rdata;
    end
endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit: randomized bench; expects a sequential instruction stream
// restarting at each redirect target, served by an in-order memory model.
module tb_rv32_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 0, rst = 0, PCSel = 0, i_imem_gnt = 0, i_imem_rvalid = 0, i_ready = 0;
  logic [31:0] i_alu_result = 0, i_imem_rdata = 0;
  logic o_imem_req, o_valid;
  logic [31:0] o_imem_addr, o_instruction, o_pc;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  rv32_fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .i_alu_result(i_alu_result),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc), .i_ready(i_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction
  logic [31:0] pend_addr[$];
  int pend_due[$];
  logic [31:0] dlog_pc[$];
  int dlog_cyc[$];
  int cyc = 0, grants = 0, delivered = 0, req_cyc = 0, flush_left = -1;
  int gnt_pct = 100, lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_pc = RPC, exp_fetch = RPC, prev_addr = 0;
  logic prev_wait = 0, last_sel = 0, first_chk = 0, last_req = 0, last_valid = 0, sel_valid = 0;
  task automatic step(input logic rdy, input logic sel, input logic [31:0] tgt);
    logic rv;
    @(negedge clk);
    rv = 0;
    i_imem_rdata = $urandom;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rv = 1;
      i_imem_rdata = mem(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    i_imem_rvalid = rv;
    i_imem_gnt = $urandom_range(0, 99) < gnt_pct;
    i_ready = rdy;
    PCSel = sel;
    i_alu_result = tgt;
    #1;
    if (first_chk) begin
      check("first_req", o_imem_req, 1);
      check("first_addr", o_imem_addr, RPC);
      req_cyc = cyc;
      first_chk = 0;
    end
    if (prev_wait) begin
      check("req_hold", o_imem_req, 1);
      check("addr_hold", o_imem_addr, prev_addr);
    end
    if (last_sel) check("redir_valid", o_valid, 0);
    if (flush_left > 0) check("flush_req", o_imem_req, 0);
    if (flush_left == 0) begin
      check("resume_req", o_imem_req, 1);
      check("resume_addr", o_imem_addr, exp_fetch);
      flush_left = -1;
    end
    if (rv && flush_left > 0) flush_left--;
    if (o_valid && rdy) begin
      check("pop_pc", o_pc, exp_pc);
      check("pop_instr", o_instruction, mem(exp_pc));
      dlog_pc.push_back(o_pc);
      dlog_cyc.push_back(cyc);
      exp_pc += 4;
      delivered++;
    end
    if (o_imem_req && i_imem_gnt) begin
      check("fetch_addr", o_imem_addr, exp_fetch);
      exp_fetch += 4;
      pend_addr.push_back(o_imem_addr);
      pend_due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
      grants++;
      check("credit", 32'(pend_addr.size() <= 2), 1);
    end
    last_req = o_imem_req;
    last_valid = o_valid;
    if (sel) begin
      sel_valid = o_valid;
      exp_pc = tgt & ~32'h3;
      exp_fetch = exp_pc;
      flush_left = pend_addr.size();
    end
    last_sel = sel;
    prev_addr = o_imem_addr;
    prev_wait = o_imem_req && !i_imem_gnt && !sel;
    @(posedge clk);
    cyc++;
  endtask
  task automatic do_reset(input logic stale);
    @(negedge clk);
    rst = 1;
    PCSel = 0;
    i_imem_gnt = 0;
    i_imem_rvalid = 0;
    i_ready = 0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_req", o_imem_req, 0);
    check("rst_addr", o_imem_addr, RPC);
    check("rst_instr", o_instruction, 32'h0000_0013);
    check("rst_pc", o_pc, RPC);
    repeat (2) @(negedge clk);
    rst = 0;
    i_imem_rvalid = stale && pend_addr.size() > 0;
    if (i_imem_rvalid) i_imem_rdata = mem(pend_addr[0]);
    #1;
    check("exit_req", o_imem_req, 0);
    pend_addr.delete();
    pend_due.delete();
    exp_pc = RPC;
    exp_fetch = RPC;
    prev_wait = 0;
    last_sel = 0;
    flush_left = -1;
    first_chk = 1;
    @(posedge clk);
    cyc++;
  endtask
  initial begin
    // streaming from reset with an always-granting, latency-1 memory
    do_reset(0);
    dlog_pc.delete(); dlog_cyc.delete();
    repeat (8) step(1, 0, 0);
    check("tp_count", 32'(dlog_pc.size() >= 3), 1);
    if (dlog_pc.size() >= 3) begin
      check("tp_pc0", dlog_pc[0], 32'h100);
      check("tp_pc1", dlog_pc[1], 32'h104);
      check("tp_pc2", dlog_pc[2], 32'h108);
      check("tp_lat", 32'(dlog_cyc[0] - req_cyc), 2);
      check("tp_gap1", 32'(dlog_cyc[1] - dlog_cyc[0]), 1);
      check("tp_gap2", 32'(dlog_cyc[2] - dlog_cyc[1]), 1);
    end
    // redirect coinciding with pop, rvalid and grant
    step(1, 1, 32'h0000_0300);
    check("simul_pop", 32'(sel_valid), 1);
    dlog_pc.delete();
    repeat (10) step(1, 0, 0);
    check("simul_count", 32'(dlog_pc.size() > 0), 1);
    if (dlog_pc.size() > 0) check("simul_first", dlog_pc[0], 32'h300);
    // PC wrap
    step(1, 1, 32'hFFFF_FFF8);
    dlog_pc.delete();
    repeat (10) step(1, 0, 0);
    check("wrap_count", 32'(dlog_pc.size() >= 3), 1);
    if (dlog_pc.size() >= 3) begin
      check("wrap_pc0", dlog_pc[0], 32'hFFFF_FFF8);
      check("wrap_pc1", dlog_pc[1], 32'hFFFF_FFFC);
      check("wrap_pc2", dlog_pc[2], 32'h0000_0000);
    end
    // backpressure: queue and credits fill, then resume in order
    do_reset(0);
    begin
      int g0, d0;
      g0 = grants;
      repeat (10) step(0, 0, 0);
      check("bp_grants", 32'(grants - g0), 2);
      check("bp_req", last_req, 0);
      d0 = delivered;
      repeat (10) step(1, 0, 0);
      check("bp_resume", 32'(delivered - d0 >= 2), 1);
    end
    // redirect with two fetches outstanding
    do_reset(0);
    lat_lo = 3; lat_hi = 3;
    repeat (2) step(0, 0, 0);
    step(0, 1, 32'h0000_0203);
    check("r2_pending", 32'(pend_addr.size()), 2);
    dlog_pc.delete();
    repeat (12) step(1, 0, 0);
    check("r2_count", 32'(dlog_pc.size() > 0), 1);
    if (dlog_pc.size() > 0) check("r2_first", dlog_pc[0], 32'h200);
    // async reset mid-stream with a response still pending
    do_reset(0);
    repeat (5) step(1, 0, 0);
    check("pre_rst_valid", last_valid, 1);
    do_reset(1);
    lat_lo = 1; lat_hi = 1;
    dlog_pc.delete();
    repeat (12) step(1, 0, 0);
    check("rst2_count", 32'(dlog_pc.size() > 0), 1);
    if (dlog_pc.size() > 0) check("rst2_first", dlog_pc[0], RPC);
    // random soak
    gnt_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      logic s;
      logic [31:0] t;
      s = $urandom_range(0, 99) < 4;
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom);
      step($urandom_range(0, 99) < 70, s, t);
    end
    gnt_pct = 100;
    repeat (20) step(1, 0, 0);
    check("soak_delivered", 32'(delivered > 500), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
